// File: rtl/sprite_pkg.sv
// Shared types and defaults for the sprite fetch engine.
// Holds the FSM state enum, default parameters and the FIFO entry layout.
package sprite_pkg;

    localparam int unsigned MEM_DEPTH_DEFAULT = 60000;
    localparam logic [7:0] TRANSPARENT_DEFAULT = 8'h00;
    localparam int unsigned COORD_W = 10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_FETCH,
        ST_DRAIN,
        ST_DONE
    } state_e;

    typedef struct packed {
        logic [7:0]         data;
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic               last;
    } pix_entry_t;

    // Last byte address touched by a sprite, 17 bits so that
    // overruns past the 16-bit address space stay visible.
    function automatic logic [16:0] span_end(
        input logic [15:0] base,
        input logic [7:0]  w,
        input logic [7:0]  h
    );
        logic [15:0] area;
        area = 16'(w) * 16'(h);
        return 17'(base) + 17'(area) - 17'd1;
    endfunction

endpackage

// File: rtl/sprite_fetch_fifo.sv
// Two-entry output FIFO holding pixel byte plus its x/y/last tags.
// Ports: clk, reset, push_i/data_i, pop_i/data_o, full_o, empty_o, count_o.
module sprite_fetch_fifo
    import sprite_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       push_i,
    input  pix_entry_t data_i,
    input  logic       pop_i,
    output pix_entry_t data_o,
    output logic       full_o,
    output logic       empty_o,
    output logic [1:0] count_o
);

    pix_entry_t mem_q [2];
    logic       wr_ptr_q;
    logic       wr_ptr_d;
    logic       rd_ptr_q;
    logic       rd_ptr_d;
    logic [1:0] count_q;
    logic [1:0] count_d;
    logic       do_push;
    logic       do_pop;

    assign do_pop  = pop_i && (count_q != 2'd0);
    // A push into a full FIFO is only legal when a pop frees a slot.
    assign do_push = push_i && ((count_q != 2'd2) || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = ~wr_ptr_q;
        end
        if (do_pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= data_i;
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign full_o  = (count_q == 2'd2);
    assign empty_o = (count_q == 2'd0);
    assign count_o = count_q;

endmodule

// File: rtl/sprite_fetch.sv
// Sprite fetch engine: reads a w x h sprite row-major from byte memory and
// streams pixels with screen coordinates. Ports: req_* request handshake,
// mem_* sprite memory read port, pix_* pixel stream, done/err completion.
module sprite_fetch
    import sprite_pkg::*;
#(
    parameter int unsigned MEM_DEPTH   = MEM_DEPTH_DEFAULT,
    parameter logic [7:0]  TRANSPARENT = TRANSPARENT_DEFAULT
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [15:0]  req_base,
    input  logic [7:0]   req_w,
    input  logic [7:0]   req_h,
    input  logic [9:0]   req_x,
    input  logic [9:0]   req_y,
    output logic [15:0]  mem_address,
    output logic         mem_chipselect,
    output logic         mem_write,
    input  logic [7:0]   mem_readdata,
    output logic         pix_valid,
    input  logic         pix_ready,
    output logic [7:0]   pix_data,
    output logic         pix_opaque,
    output logic [9:0]   pix_x,
    output logic [9:0]   pix_y,
    output logic         pix_last,
    output logic         done,
    output logic         err
);

    state_e      state_q;
    state_e      state_d;
    logic        err_q;
    logic        err_d;
    logic [15:0] base_q;
    logic [15:0] base_d;
    logic [7:0]  w_q;
    logic [7:0]  w_d;
    logic [7:0]  h_q;
    logic [7:0]  h_d;
    logic [9:0]  x_q;
    logic [9:0]  x_d;
    logic [9:0]  y_q;
    logic [9:0]  y_d;
    logic [15:0] addr_q;
    logic [15:0] addr_d;
    logic [15:0] last_addr_q;
    logic [15:0] last_addr_d;
    logic [7:0]  col_q;
    logic [7:0]  col_d;
    logic [7:0]  row_q;
    logic [7:0]  row_d;
    logic        pend_q;
    logic        pend_d;
    logic [9:0]  pend_x_q;
    logic [9:0]  pend_x_d;
    logic [9:0]  pend_y_q;
    logic [9:0]  pend_y_d;
    logic        pend_last_q;
    logic        pend_last_d;

    logic        accept;
    logic        issue;
    logic        pop;
    logic        last_rd;
    logic        credit_ok;
    logic [2:0]  credit;
    logic [16:0] end_addr;

    pix_entry_t  fifo_in;
    pix_entry_t  fifo_head;
    logic        fifo_full;
    logic        fifo_empty;
    logic [1:0]  fifo_count;
    logic        fifo_push;

    assign req_ready = !reset && (state_q == ST_IDLE);
    assign accept    = req_ready && req_valid;

    assign pix_valid = !reset && !fifo_empty;
    assign pop       = pix_valid && pix_ready;

    // Buffered plus in-flight minus leaving this cycle must stay below
    // two so a returning read always finds a free FIFO slot.
    assign credit    = {1'b0, fifo_count} + {2'b00, pend_q}
                     - {2'b00, pop};
    assign credit_ok = (credit < 3'd2);

    assign issue   = !reset && (state_q == ST_FETCH) && credit_ok;
    assign last_rd = (col_q == w_q - 8'd1) && (row_q == h_q - 8'd1);

    assign end_addr = span_end(base_q, w_q, h_q);

    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_CHECK;
                    err_d   = 1'b0;
                end
            end
            ST_CHECK: begin
                if ((w_q == 8'd0) || (h_q == 8'd0)) begin
                    state_d = ST_DONE;
                    err_d   = 1'b0;
                end else if (end_addr > 17'(MEM_DEPTH - 1)) begin
                    state_d = ST_DONE;
                    err_d   = 1'b1;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (issue && last_rd) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (pop && fifo_head.last) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        base_d      = base_q;
        w_d         = w_q;
        h_d         = h_q;
        x_d         = x_q;
        y_d         = y_q;
        addr_d      = addr_q;
        col_d       = col_q;
        row_d       = row_q;
        last_addr_d = last_addr_q;
        pend_d      = issue;
        pend_x_d    = pend_x_q;
        pend_y_d    = pend_y_q;
        pend_last_d = pend_last_q;
        if (accept) begin
            base_d = req_base;
            w_d    = req_w;
            h_d    = req_h;
            x_d    = req_x;
            y_d    = req_y;
            addr_d = req_base;
            col_d  = 8'd0;
            row_d  = 8'd0;
        end
        if (issue) begin
            addr_d      = addr_q + 16'd1;
            last_addr_d = addr_q;
            // Coordinates wrap naturally in 10 bits.
            pend_x_d    = x_q + 10'(col_q);
            pend_y_d    = y_q + 10'(row_q);
            pend_last_d = last_rd;
            if (col_q == w_q - 8'd1) begin
                col_d = 8'd0;
                row_d = row_q + 8'd1;
            end else begin
                col_d = col_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            err_q       <= 1'b0;
            base_q      <= '0;
            w_q         <= '0;
            h_q         <= '0;
            x_q         <= '0;
            y_q         <= '0;
            addr_q      <= '0;
            last_addr_q <= '0;
            col_q       <= '0;
            row_q       <= '0;
            pend_q      <= 1'b0;
            pend_x_q    <= '0;
            pend_y_q    <= '0;
            pend_last_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            err_q       <= err_d;
            base_q      <= base_d;
            w_q         <= w_d;
            h_q         <= h_d;
            x_q         <= x_d;
            y_q         <= y_d;
            addr_q      <= addr_d;
            last_addr_q <= last_addr_d;
            col_q       <= col_d;
            row_q       <= row_d;
            pend_q      <= pend_d;
            pend_x_q    <= pend_x_d;
            pend_y_q    <= pend_y_d;
            pend_last_q <= pend_last_d;
        end
    end

    // pend_q marks the return cycle of a read issued last cycle.
    assign fifo_push    = pend_q && (!fifo_full || pop);
    assign fifo_in.data = mem_readdata;
    assign fifo_in.x    = pend_x_q;
    assign fifo_in.y    = pend_y_q;
    assign fifo_in.last = pend_last_q;

    sprite_fetch_fifo u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (fifo_push),
        .data_i  (fifo_in),
        .pop_i   (pop),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign mem_chipselect = issue;
    assign mem_address    = issue ? addr_q : last_addr_q;
    assign mem_write      = 1'b0;

    assign pix_data   = pix_valid ? fifo_head.data : 8'd0;
    assign pix_x      = pix_valid ? fifo_head.x : 10'd0;
    assign pix_y      = pix_valid ? fifo_head.y : 10'd0;
    assign pix_last   = pix_valid && fifo_head.last;
    assign pix_opaque = pix_valid && (fifo_head.data != TRANSPARENT);

    assign done = !reset && (state_q == ST_DONE);
    assign err  = done && err_q;

endmodule

// File: tb/tb_sprite_fetch.sv
// Self-checking bench for sprite_fetch: directed and random requests
// compared against a row-major reference model of the sprite walk.
module tb_sprite_fetch;

    localparam int MEMD = 60000;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [15:0] req_base;
    logic [7:0]  req_w;
    logic [7:0]  req_h;
    logic [9:0]  req_x;
    logic [9:0]  req_y;
    logic [15:0] mem_address;
    logic        mem_chipselect;
    logic        mem_write;
    logic [7:0]  mem_readdata;
    logic        pix_valid;
    logic        pix_ready;
    logic [7:0]  pix_data;
    logic        pix_opaque;
    logic [9:0]  pix_x;
    logic [9:0]  pix_y;
    logic        pix_last;
    logic        done;
    logic        err;

    sprite_fetch dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_base       (req_base),
        .req_w          (req_w),
        .req_h          (req_h),
        .req_x          (req_x),
        .req_y          (req_y),
        .mem_address    (mem_address),
        .mem_chipselect (mem_chipselect),
        .mem_write      (mem_write),
        .mem_readdata   (mem_readdata),
        .pix_valid      (pix_valid),
        .pix_ready      (pix_ready),
        .pix_data       (pix_data),
        .pix_opaque     (pix_opaque),
        .pix_x          (pix_x),
        .pix_y          (pix_y),
        .pix_last       (pix_last),
        .done           (done),
        .err            (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] mem [65536];
    logic [7:0] rdata_q;
    always @(posedge clk) begin
        if (mem_chipselect) rdata_q <= mem[mem_address];
    end
    assign mem_readdata = rdata_q;

    int checks = 0;
    int errors = 0;

    int rd_addr [$];
    int rd_cyc  [$];
    int px_data [$];
    int px_x    [$];
    int px_y    [$];
    int px_last [$];
    int px_opq  [$];
    int px_cyc  [$];
    int done_cnt;
    int done_cyc;
    int done_err;
    int max_out;
    int timed_out;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_req(input logic [15:0] b, input logic [7:0] w,
                           input logic [7:0] h, input logic [9:0] x,
                           input logic [9:0] y, input int mode,
                           input int abort_at);
        int k;
        int step;
        int issued;
        int popped;
        int limit;
        bit fin;
        rd_addr.delete(); rd_cyc.delete();
        px_data.delete(); px_x.delete(); px_y.delete();
        px_last.delete(); px_opq.delete(); px_cyc.delete();
        done_cnt = 0; done_cyc = -1; done_err = 0;
        max_out = 0; timed_out = 0;
        issued = 0; popped = 0; step = 0;
        limit = 40 * (int'(w) * int'(h)) + 40;
        check("req_ready_before_req", req_ready, 1);
        req_valid = 1'b1;
        req_base = b; req_w = w; req_h = h; req_x = x; req_y = y;
        pix_ready = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        k = 1;
        fin = 0;
        while (!fin) begin
            @(negedge clk);
            if (mem_chipselect) begin
                rd_addr.push_back(int'(mem_address));
                rd_cyc.push_back(k);
                issued++;
            end
            if (pix_valid && pix_ready) begin
                px_data.push_back(int'(pix_data));
                px_x.push_back(int'(pix_x));
                px_y.push_back(int'(pix_y));
                px_last.push_back(int'(pix_last));
                px_opq.push_back(int'(pix_opaque));
                px_cyc.push_back(k);
                popped++;
            end
            if (issued - popped > max_out) max_out = issued - popped;
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) begin
                    done_cyc = k;
                    done_err = int'(err);
                end
            end
            if (k == abort_at) begin
                reset = 1'b1;
                fin = 1;
            end else if (done_cyc >= 0 && k > done_cyc) begin
                fin = 1;
            end else if (k >= limit) begin
                timed_out = 1;
                fin = 1;
            end
            if (mode == 1) begin
                step++;
                if (step == 1 || step == 2) pix_ready = 1'b0;
                else if (step == 3) pix_ready = 1'b1;
                else pix_ready = 1'($urandom_range(0, 1));
            end
            k++;
        end
    endtask

    task automatic verify(input string tag, input logic [15:0] b,
                          input logic [7:0] w, input logic [7:0] h,
                          input logic [9:0] x, input logic [9:0] y,
                          input int mode);
        int n;
        int e;
        int m;
        int c;
        int r;
        int d;
        n = int'(w) * int'(h);
        e = 0;
        if (w == 0 || h == 0) n = 0;
        else if (int'(b) + n - 1 > MEMD - 1) begin
            e = 1;
            n = 0;
        end
        check({tag, "_timeout"}, timed_out, 0);
        check({tag, "_done_pulses"}, done_cnt, 1);
        check({tag, "_err"}, done_err, e);
        check({tag, "_npix"}, px_data.size(), n);
        check({tag, "_nreads"}, rd_addr.size(), n);
        check({tag, "_outstanding_le2"}, max_out <= 2, 1);
        check({tag, "_idle_after_done"}, req_ready, 1);
        check({tag, "_done_low_after"}, done, 0);
        if (n == 0) check({tag, "_done_cycle"}, done_cyc, 2);
        m = (px_data.size() < n) ? px_data.size() : n;
        for (int i = 0; i < m; i++) begin
            r = i / int'(w);
            c = i % int'(w);
            d = int'(mem[int'(b) + i]);
            check($sformatf("%s_data%0d", tag, i), px_data[i], d);
            check($sformatf("%s_x%0d", tag, i), px_x[i],
                  (int'(x) + c) % 1024);
            check($sformatf("%s_y%0d", tag, i), px_y[i],
                  (int'(y) + r) % 1024);
            check($sformatf("%s_last%0d", tag, i), px_last[i],
                  (i == n - 1) ? 1 : 0);
            check($sformatf("%s_opq%0d", tag, i), px_opq[i],
                  (d != 0) ? 1 : 0);
        end
        m = (rd_addr.size() < n) ? rd_addr.size() : n;
        for (int i = 0; i < m; i++) begin
            check($sformatf("%s_raddr%0d", tag, i), rd_addr[i],
                  (int'(b) + i) & 32'hFFFF);
        end
        if (mode == 0 && n > 0) begin
            check({tag, "_done_cycle"}, done_cyc, n + 4);
            for (int i = 0; i < m; i++) begin
                check($sformatf("%s_rcyc%0d", tag, i), rd_cyc[i], 2 + i);
            end
            m = (px_cyc.size() < n) ? px_cyc.size() : n;
            for (int i = 0; i < m; i++) begin
                check($sformatf("%s_pcyc%0d", tag, i), px_cyc[i], 4 + i);
            end
        end
    endtask

    initial begin
        logic [15:0] rb;
        logic [7:0]  rw;
        logic [7:0]  rh;
        logic [9:0]  rx;
        logic [9:0]  ry;
        int          rm;

        for (int i = 0; i < 65536; i++) begin
            mem[i] = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
        end
        rdata_q   = 8'h00;
        reset     = 1'b1;
        req_valid = 1'b0;
        req_base  = '0;
        req_w     = '0;
        req_h     = '0;
        req_x     = '0;
        req_y     = '0;
        pix_ready = 1'b1;

        repeat (2) @(negedge clk);
        check("rst_req_ready", req_ready, 0);
        check("rst_pix_valid", pix_valid, 0);
        check("rst_pix_last", pix_last, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_cs", mem_chipselect, 0);
        check("rst_addr", mem_address, 0);
        check("rst_pix_data", pix_data, 0);
        check("rst_pix_x", pix_x, 0);
        check("rst_pix_y", pix_y, 0);
        check("mem_write_low", mem_write, 0);
        reset = 1'b0;
        #1 check("post_rst_req_ready", req_ready, 1);

        run_req(16'h0100, 8'd2, 8'd2, 10'd5, 10'd7, 0, 0);
        verify("basic2x2", 16'h0100, 8'd2, 8'd2, 10'd5, 10'd7, 0);
        check("addr_hold", mem_address, 16'h0103);
        check("cs_idle", mem_chipselect, 0);

        run_req(16'd59990, 8'd4, 8'd4, 10'd0, 10'd0, 0, 0);
        verify("overrun", 16'd59990, 8'd4, 8'd4, 10'd0, 10'd0, 0);

        run_req(16'h0040, 8'd0, 8'd10, 10'd1, 10'd1, 0, 0);
        verify("zero_w", 16'h0040, 8'd0, 8'd10, 10'd1, 10'd1, 0);

        rb = 16'($urandom_range(0, 50000));
        run_req(rb, 8'd8, 8'd1, 10'd100, 10'd200, 1, 0);
        verify("backpr8x1", rb, 8'd8, 8'd1, 10'd100, 10'd200, 1);

        run_req(16'h0300, 8'd4, 8'd2, 10'd1022, 10'd1023, 0, 0);
        verify("xwrap", 16'h0300, 8'd4, 8'd2, 10'd1022, 10'd1023, 0);

        run_req(16'd59984, 8'd4, 8'd4, 10'd9, 10'd9, 0, 0);
        verify("exact_top", 16'd59984, 8'd4, 8'd4, 10'd9, 10'd9, 0);

        for (int t = 0; t < 16; t++) begin
            rw = 8'($urandom_range(0, 6));
            rh = 8'($urandom_range(0, 6));
            if ($urandom_range(0, 3) == 0)
                rb = 16'(59970 + $urandom_range(0, 40));
            else
                rb = 16'($urandom_range(0, 59000));
            rx = 10'($urandom);
            ry = 10'($urandom);
            rm = int'($urandom_range(0, 1));
            run_req(rb, rw, rh, rx, ry, rm, 0);
            verify($sformatf("rand%0d", t), rb, rw, rh, rx, ry, rm);
        end

        run_req(16'h0200, 8'd4, 8'd4, 10'd3, 10'd3, 0, 5);
        check("abort_saw_reads", rd_addr.size() > 0, 1);
        @(negedge clk);
        check("inrst_req_ready", req_ready, 0);
        check("inrst_pix_valid", pix_valid, 0);
        check("inrst_done", done, 0);
        reset = 1'b0;
        #1;
        check("abort_pix_valid", pix_valid, 0);
        check("abort_cs", mem_chipselect, 0);
        check("abort_req_ready", req_ready, 1);
        check("abort_pix_last", pix_last, 0);
        repeat (3) @(negedge clk);
        check("abort_quiet_pix", pix_valid, 0);
        check("abort_quiet_cs", mem_chipselect, 0);

        run_req(16'h0500, 8'd3, 8'd3, 10'd20, 10'd30, 0, 0);
        verify("after_abort", 16'h0500, 8'd3, 8'd3, 10'd20, 10'd30, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sprite_fetch.md
SPRITE_FETCH -- requirements
Module: sprite_fetch

Interface
REQ-001 Parameter MEM_DEPTH, default 60000, words in sprite memory; valid addresses 0..MEM_DEPTH-1.
REQ-002 Parameter TRANSPARENT, default 8'h00, colour-key byte.
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 req_valid/req_ready  in/out  1/1  draw-request handshake; transfer when both high.
REQ-006 req_base  in  16  sprite start address, row-major bytes.
REQ-007 req_w, req_h  in  8/8  sprite width/height in pixels.
REQ-008 req_x, req_y  in  10/10  screen origin of sprite.
REQ-009 mem_address  out  16  to sprite memory (address registered in memory, readdata valid next cycle).
REQ-010 mem_chipselect  out  1  read strobe; mem_write out 1 tied 0.
REQ-011 mem_readdata  in  8  memory data, valid the cycle after mem_chipselect.
REQ-012 pix_valid/pix_ready  out/in  1/1  pixel-stream handshake.
REQ-013 pix_data  out  8  pixel byte; pix_opaque out 1 = (pix_data != TRANSPARENT).
REQ-014 pix_x, pix_y  out  10/10  screen coordinates of pix_data.
REQ-015 pix_last  out  1  high with final pixel of a request.
REQ-016 done  out  1  one-cycle pulse at request completion; err out 1 qualifies done.

Function
REQ-017 States: IDLE, CHECK, FETCH, DRAIN, DONE.
REQ-018 IDLE: req_ready=1; on transfer latch all req_* fields, go CHECK; req_ready=0 in all other states.
REQ-019 CHECK (1 cycle): compute end = base + w*h - 1 at 17 bits; if w==0 or h==0 go DONE with err=0 and no pixels; if end > MEM_DEPTH-1 go DONE with err=1, no memory reads; else go FETCH.
REQ-020 FETCH: issue reads at base, base+1, ... in row-major order; column counter 0..w-1 then row counter 0..h-1.
REQ-021 Credit rule: issue read only when (FIFO occupancy + reads in flight - pop this cycle) < 2; at most one read per cycle.
REQ-022 Returned readdata written into 2-entry output FIFO at end of return cycle with its x,y, last tags.
REQ-023 Latency: transfer at edge 0 -> CHECK cycle 1 -> first mem_chipselect cycle 2 -> pix_valid high cycle 4.
REQ-024 With pix_ready held high, sustained throughput one pixel per cycle.
REQ-025 pix_x = req_x + col, pix_y = req_y + row, each modulo 1024 (wrap, no error).
REQ-026 pix_valid held with stable pix_data/x/y/last until pix_ready; no loss or duplication under any backpressure.
REQ-027 After last read issued go DRAIN; leave DRAIN when pix_last handshake completes, go DONE.
REQ-028 DONE: done=1 for exactly one cycle (err valid same cycle), then IDLE; next req accepted no earlier than following cycle.
REQ-029 mem_address holds last value when mem_chipselect=0.

Reset
REQ-030 reset at any time, including mid-request: next cycle state=IDLE, FIFO and credits cleared, in-flight read data discarded.
REQ-031 Reset values: req_ready=0 during reset then 1, pix_valid=0, pix_last=0, done=0, err=0, mem_chipselect=0, mem_address=0, pix_data/x/y=0.

Structure
REQ-032 Package sprite_pkg holds state enum, MEM_DEPTH default, TRANSPARENT default, coordinate width 10.
REQ-033 One sub-module: sprite_fetch_fifo, 2-entry FIFO of {data 8, x 10, y 10, last 1} with full/empty/count.

Verification
REQ-034 base=0x0100, w=2, h=2, x=5, y=7, pix_ready=1 -> reads 0x0100..0x0103 cycles 2..5; pixels (5,7),(6,7),(5,8),(6,8); pix_last on 4th; done one cycle after.
REQ-035 base=59990, w=4, h=4 (end 60005) -> no mem_chipselect, no pix_valid, done=1 err=1 at cycle 2.
REQ-036 w=0, h=10 -> done=1 err=0 at cycle 2, no reads.
REQ-037 w=8, h=1, pix_ready toggling 1,0,0,1,... random -> 8 pixels in order, data matches memory, never >2 outstanding+buffered.
REQ-038 x=1022, w=4 -> pix_x sequence 1022,1023,0,1.
REQ-039 reset asserted cycle 5 of a 16-pixel request -> cycle after: pix_valid=0, mem_chipselect=0, req_ready=1; new request then completes correctly.
